sim_step_scheduler: RTL and testbench

Sequences the Game of Life generation engine.
- Turns run/pause/single-step/speed commands into one-cycle o_step_go pulses at a programmable generation period.
- Waits for the engine's completion pulse between steps and counts generations.
- Drives o_is_simulating, which interlocks with the field config loader controller: the loader may start only while no step is in flight, and the scheduler issues no step while a load is pending or active.

---
 rtl/sim_step_scheduler_pkg.sv | 20 ++
 rtl/sim_step_scheduler_period_timer.sv | 72 +++++++
 rtl/sim_step_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_sim_step_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_step_scheduler_pkg.sv
// Shared definitions for the Game of Life step scheduler: FSM state encoding
// and default sizing used by the top level and the period timer.
package sim_step_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    STEP_GO   = 2'd2,
    STEP_WAIT = 2'd3
  } sched_state_t;

  localparam int DEF_BASE_PERIOD = 25_000_000;
  localparam int DEF_SPEED_W     = 3;
  localparam int DEF_GEN_W       = 16;

`ifdef SCHED_WATCHDOG_EN
  localparam int DEF_WDOG_CYCLES = 1_000_000;
`endif

endpackage

// File: rtl/sim_step_scheduler_period_timer.sv
// Generation period timer: holds the speed level and the cycle counter used
// while the scheduler waits between steps. tick_o is high once the counter
// has reached period-1 (or beyond, after a speed increase shortened the
// period); the counter then holds until cleared.
module sched_period_timer
  import sim_step_scheduler_pkg::*;
#(
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int SPEED_W     = DEF_SPEED_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               count_en_i,
  input  logic               faster_i,
  input  logic               slower_i,
  output logic               tick_o,
  output logic [SPEED_W-1:0] speed_o
);

  localparam int                 PER_W     = $clog2(BASE_PERIOD + 1);
  localparam logic [PER_W-1:0]   BASE_VAL  = PER_W'(BASE_PERIOD);
  localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [PER_W-1:0]   cnt_q, cnt_d;
  logic [PER_W-1:0]   period, period_m1;

  // Saturating speed level; simultaneous faster and slower cancel out
  always_comb begin
    speed_d = speed_q;
    if (faster_i && !slower_i && (speed_q != SPEED_MAX)) begin
      speed_d = speed_q + 1'b1;
    end else if (slower_i && !faster_i && (speed_q != '0)) begin
      speed_d = speed_q - 1'b1;
    end
  end

  // Period for the current speed, never shorter than one cycle
  always_comb begin
    period = BASE_VAL >> speed_q;
    if (period == '0) begin
      period = PER_W'(1);
    end
    period_m1 = period - PER_W'(1);
  end

  assign tick_o  = (cnt_q >= period_m1);
  assign speed_o = speed_q;

  // Counter climbs to period-1 and then holds until the scheduler clears it
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && !tick_o) begin
      cnt_d = cnt_q + PER_W'(1);
    end
  end

  // Speed and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= '0;
      cnt_q   <= '0;
    end else begin
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sim_step_scheduler.sv
// Game of Life step scheduler: turns run/pause/step/speed commands into
// one-cycle step pulses for the generation engine, waits for the engine to
// finish each generation, counts generations and interlocks with the field
// loader through o_is_simulating / i_load_pending / i_is_loading.
// Optional step watchdog enabled by defining SCHED_WATCHDOG_EN.
module sim_step_scheduler
  import sim_step_scheduler_pkg::*;
#(
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int SPEED_W     = DEF_SPEED_W,
  parameter int GEN_W       = DEF_GEN_W
`ifdef SCHED_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cmd_run_toggle,
  input  logic               i_cmd_step,
  input  logic               i_cmd_faster,
  input  logic               i_cmd_slower,
  input  logic               i_load_pending,
  input  logic               i_is_loading,
  input  logic               i_step_done,
  output logic               o_step_go,
  output logic               o_is_simulating,
  output logic               o_running,
  output logic [SPEED_W-1:0] o_speed,
  output logic [GEN_W-1:0]   o_gen_count,
  output logic               o_fault
);

  sched_state_t     state_q, state_d;
  logic             running_q, running_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             loading_q;
  logic             blocked;
  logic             load_done;
  logic             tick;
  logic             timer_clear;
  logic             wdog_expire;

  assign blocked   = i_load_pending | i_is_loading;
  assign load_done = loading_q & ~i_is_loading;

  // The counter restarts from zero on every WAIT_TICK entry and is idle elsewhere
  assign timer_clear = (state_d != WAIT_TICK);

  sched_period_timer #(
    .BASE_PERIOD(BASE_PERIOD),
    .SPEED_W    (SPEED_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (timer_clear),
    .count_en_i(state_q == WAIT_TICK),
    .faster_i  (i_cmd_faster),
    .slower_i  (i_cmd_slower),
    .tick_o    (tick),
    .speed_o   (o_speed)
  );

`ifdef SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              fault_q, fault_d;

  assign wdog_expire = (state_q == STEP_WAIT) && !i_step_done &&
                       (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

  // Count cycles spent waiting for the engine; a new command clears the fault
  always_comb begin
    wdog_d  = '0;
    fault_d = fault_q;
    if ((state_q == STEP_WAIT) && !i_step_done) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
    if (i_cmd_run_toggle || i_cmd_step) begin
      fault_d = 1'b0;
    end
    if (wdog_expire) begin
      fault_d = 1'b1;
    end
  end

  // Watchdog counter and sticky fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
    end
  end

  assign o_fault = fault_q;
`else
  assign wdog_expire = 1'b0;
  assign o_fault     = 1'b0;
`endif

  // Next-state logic; run_toggle beats step, and a started step always finishes
  always_comb begin
    state_d   = state_q;
    running_d = running_q;
    case (state_q)
      IDLE: begin
        if (i_cmd_run_toggle) begin
          running_d = 1'b1;
          state_d   = WAIT_TICK;
        end else if (i_cmd_step && !blocked) begin
          state_d = STEP_GO;
        end
      end
      WAIT_TICK: begin
        if (i_cmd_run_toggle) begin
          running_d = 1'b0;
          state_d   = IDLE;
        end else if (tick && !blocked) begin
          state_d = STEP_GO;
        end
      end
      STEP_GO: begin
        if (i_cmd_run_toggle) begin
          running_d = ~running_q;
        end
        state_d = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (i_cmd_run_toggle) begin
          running_d = ~running_q;
        end
        if (wdog_expire) begin
          running_d = 1'b0;
          state_d   = IDLE;
        end else if (i_step_done) begin
          state_d = running_d ? WAIT_TICK : IDLE;
        end
      end
      default: begin
        running_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Generation count; a freshly loaded field restarts it even on a completion cycle
  always_comb begin
    gen_d = gen_q;
    if (load_done) begin
      gen_d = '0;
    end else if ((state_q == STEP_WAIT) && i_step_done) begin
      gen_d = gen_q + 1'b1;
    end
  end

  // State, run flag, generation counter and loader edge-detect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      gen_q     <= '0;
      loading_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      gen_q     <= gen_d;
      loading_q <= i_is_loading;
    end
  end

  assign o_step_go       = (state_q == STEP_GO);
  assign o_is_simulating = (state_q == STEP_GO) || (state_q == STEP_WAIT);
  assign o_running       = running_q;
  assign o_gen_count     = gen_q;

endmodule

// File: tb/tb_sim_step_scheduler.sv
// Scoreboard bench for sim_step_scheduler with BASE_PERIOD=16, SPEED_W=3.
// Stimulus pushes the expected cycle/generation/run flag of every step pulse;
// a monitor pops one entry per observed o_step_go. A small engine model
// answers each step pulse with i_step_done two cycles later.
module tb_sim_step_scheduler;

  localparam int BASE = 16;
  localparam int SPW  = 3;
  localparam int GW   = 16;

  localparam int CMD_RUN  = 0;
  localparam int CMD_STEP = 1;
  localparam int CMD_FAST = 2;
  localparam int CMD_SLOW = 3;
  localparam int CMD_BOTH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmdRun = 1'b0;
  logic           cmdStep = 1'b0;
  logic           cmdFast = 1'b0;
  logic           cmdSlow = 1'b0;
  logic           loadPending = 1'b0;
  logic           isLoading = 1'b0;
  logic           stepDone = 1'b0;
  logic           stepGo;
  logic           isSim;
  logic           running;
  logic [SPW-1:0] speed;
  logic [GW-1:0]  genCount;
  logic           fault;

  logic engineEn = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          cyc;
    logic [GW-1:0] gen;
    logic        run;
  } goExp_t;

  goExp_t expQ[$];

  sim_step_scheduler #(
    .BASE_PERIOD(BASE),
    .SPEED_W    (SPW),
    .GEN_W      (GW)
`ifdef SCHED_WATCHDOG_EN
    ,
    .WDOG_CYCLES(32)
`endif
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_cmd_run_toggle(cmdRun),
    .i_cmd_step      (cmdStep),
    .i_cmd_faster    (cmdFast),
    .i_cmd_slower    (cmdSlow),
    .i_load_pending  (loadPending),
    .i_is_loading    (isLoading),
    .i_step_done     (stepDone),
    .o_step_go       (stepGo),
    .o_is_simulating (isSim),
    .o_running       (running),
    .o_speed         (speed),
    .o_gen_count     (genCount),
    .o_fault         (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic expectGo(input int c, input int g, input logic r);
    goExp_t e;
    e.cyc = c;
    e.gen = GW'(g);
    e.run = r;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int kind);
    case (kind)
      CMD_RUN:  cmdRun = 1'b1;
      CMD_STEP: cmdStep = 1'b1;
      CMD_FAST: cmdFast = 1'b1;
      CMD_SLOW: cmdSlow = 1'b1;
      default: begin
        cmdFast = 1'b1;
        cmdSlow = 1'b1;
      end
    endcase
    tick(1);
    cmdRun  = 1'b0;
    cmdStep = 1'b0;
    cmdFast = 1'b0;
    cmdSlow = 1'b0;
  endtask

  // Monitor: every step pulse must match the oldest expected entry
  always @(negedge clk) begin : monitor
    goExp_t e;
    if (rst_n && stepGo === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_go at cycle %0d: got step pulse expected none", cyc);
      end else begin
        e = expQ.pop_front();
        checkOutput("go_cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("go_gen", 64'(genCount), 64'(e.gen));
        checkOutput("go_running", 64'(running), 64'(e.run));
        checkOutput("go_is_sim", 64'(isSim), 64'd1);
      end
    end
  end

  // Engine model: completion pulse two cycles after each step pulse
  always begin
    @(negedge clk);
    if (rst_n && stepGo === 1'b1 && engineEn) begin
      repeat (2) @(posedge clk);
      #1 stepDone = 1'b1;
      @(posedge clk);
      #1 stepDone = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int k, s, r, q, q2;
`ifdef SCHED_WATCHDOG_EN
    int w;
`endif
    tick(3);
    checkOutput("rst_step_go", 64'(stepGo), 64'd0);
    checkOutput("rst_is_sim", 64'(isSim), 64'd0);
    checkOutput("rst_running", 64'(running), 64'd0);
    checkOutput("rst_speed", 64'(speed), 64'd0);
    checkOutput("rst_gen", 64'(genCount), 64'd0);
    checkOutput("rst_fault", 64'(fault), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Free-running at speed 0: 16-cycle wait, done 2 cycles after go -> 19 spacing
    k = cyc;
    expectGo(k + 17, 0, 1'b1);
    expectGo(k + 36, 1, 1'b1);
    expectGo(k + 55, 2, 1'b1);
    applyStimulus(CMD_RUN);
    waitUntil(k + 60);
    applyStimulus(CMD_RUN);
    checkOutput("pause_gen", 64'(genCount), 64'd3);
    checkOutput("pause_running", 64'(running), 64'd0);
    checkOutput("pause_is_sim", 64'(isSim), 64'd0);

    // Single step while paused
    s = cyc;
    expectGo(s + 1, 3, 1'b0);
    applyStimulus(CMD_STEP);
    tick(1);
    checkOutput("step_wait_is_sim", 64'(isSim), 64'd1);
    waitUntil(s + 5);
    checkOutput("step_gen", 64'(genCount), 64'd4);
    checkOutput("step_is_sim", 64'(isSim), 64'd0);

    // Step commands while running are ignored
    r = cyc;
    expectGo(r + 17, 4, 1'b1);
    applyStimulus(CMD_RUN);
    waitUntil(r + 5);
    applyStimulus(CMD_STEP);
    waitUntil(r + 18);
    applyStimulus(CMD_STEP);

    // Loader holds off the tick; go fires on the first unblocked cycle
    waitUntil(r + 30);
    loadPending = 1'b1;
    waitUntil(r + 40);
    loadPending = 1'b0;
    isLoading = 1'b1;
    waitUntil(r + 45);
    isLoading = 1'b0;
    checkOutput("blocked_gen", 64'(genCount), 64'd5);
    checkOutput("blocked_is_sim", 64'(isSim), 64'd0);
    expectGo(r + 46, 0, 1'b1);
    expectGo(r + 65, 1, 1'b1);
    waitUntil(r + 70);
    applyStimulus(CMD_RUN);
    checkOutput("load_gen", 64'(genCount), 64'd2);
    checkOutput("load_running", 64'(running), 64'd0);

    // Speed 3 gives period 2; simultaneous faster/slower leaves speed alone
    repeat (3) applyStimulus(CMD_FAST);
    checkOutput("speed3", 64'(speed), 64'd3);
    applyStimulus(CMD_BOTH);
    checkOutput("speed3_both", 64'(speed), 64'd3);
    q = cyc;
    expectGo(q + 3, 2, 1'b1);
    expectGo(q + 8, 3, 1'b1);
    expectGo(q + 13, 4, 1'b1);
    applyStimulus(CMD_RUN);
    waitUntil(q + 16);
    applyStimulus(CMD_RUN);
    checkOutput("fast_gen", 64'(genCount), 64'd5);
    checkOutput("fast_running", 64'(running), 64'd0);

    // Saturate at 7 (period 1), then pause during STEP_WAIT
    repeat (8) applyStimulus(CMD_FAST);
    checkOutput("speed_sat", 64'(speed), 64'd7);
    applyStimulus(CMD_BOTH);
    checkOutput("speed_sat_both", 64'(speed), 64'd7);
    q2 = cyc;
    expectGo(q2 + 2, 5, 1'b1);
    expectGo(q2 + 6, 6, 1'b1);
    expectGo(q2 + 10, 7, 1'b1);
    applyStimulus(CMD_RUN);
    waitUntil(q2 + 11);
    applyStimulus(CMD_RUN);
    checkOutput("toggle_in_wait_running", 64'(running), 64'd0);
    checkOutput("toggle_in_wait_is_sim", 64'(isSim), 64'd1);
    waitUntil(q2 + 20);
    checkOutput("toggle_in_wait_gen", 64'(genCount), 64'd8);
    checkOutput("toggle_in_wait_idle", 64'(isSim), 64'd0);

    // Slower from saturation, then a blocked step is dropped
    applyStimulus(CMD_SLOW);
    checkOutput("speed_slower", 64'(speed), 64'd6);
    loadPending = 1'b1;
    applyStimulus(CMD_STEP);
    loadPending = 1'b0;
    tick(5);
    checkOutput("blocked_step_is_sim", 64'(isSim), 64'd0);
    checkOutput("blocked_step_gen", 64'(genCount), 64'd8);

`ifdef SCHED_WATCHDOG_EN
    // Engine never answers: fault after 32 cycles in STEP_WAIT, cleared by step
    engineEn = 1'b0;
    w = cyc;
    expectGo(w + 1, 8, 1'b0);
    applyStimulus(CMD_STEP);
    waitUntil(w + 33);
    checkOutput("wdog_pre_fault", 64'(fault), 64'd0);
    waitUntil(w + 34);
    checkOutput("wdog_fault", 64'(fault), 64'd1);
    checkOutput("wdog_running", 64'(running), 64'd0);
    checkOutput("wdog_is_sim", 64'(isSim), 64'd0);
    engineEn = 1'b1;
    expectGo(w + 35, 8, 1'b0);
    applyStimulus(CMD_STEP);
    checkOutput("wdog_fault_clear", 64'(fault), 64'd0);
    waitUntil(w + 40);
    checkOutput("wdog_gen", 64'(genCount), 64'd9);
`endif

    tick(10);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
